noc_mcast_injector: RTL

Local-port injection stage that sits directly upstream of the router local input port.
- Accepts a multicast send request (source, up to 6 destinations with valid mask, message type, payload length) plus a payload word stream.
- Builds a packet_info_t head flit, serialises it and the payload into flits, and drives them into the router under credit-based flow control.
- Guarantees one packet in flight at a time, with no flit ever issued without a credit.

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/noc_credit_counter.sv | 42 ++++
 rtl/noc_mcast_injector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: coordinates, message kinds, flit layout and
// the packet header carried in the body of every head flit.
package noc;

    localparam int PortQueueDepth = 4;
    localparam int CreditsWidth   = $clog2(PortQueueDepth + 1);
    localparam int FlitDataWidth  = 64;
    localparam int NumDest        = 6;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } xy_t;

    typedef enum logic [4:0] {
        MSG_REQ,
        MSG_RESP,
        MSG_INV,
        MSG_ACK,
        MSG_DATA
    } message_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef struct packed {
        xy_t                   source;
        xy_t [NumDest-1:0]     dest;
        message_t              msg;
        logic [NumDest-1:0]    val;
    } packet_info_t;

    typedef struct packed {
        preamble_t                pre;
        logic [FlitDataWidth-1:0] body;
    } flit_t;

    // Tail is left clear; the caller knows whether a payload follows.
    function automatic flit_t make_head_flit(packet_info_t info);
        flit_t f;
        f.pre.head = 1'b1;
        f.pre.tail = 1'b0;
        f.body     = FlitDataWidth'(info);
        return f;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag;
// starts full, shared by the injector and router output ports.
module noc_credit_counter #(
    parameter int Max   = 4,
    parameter int Width = $clog2(Max + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [Width-1:0] o_count,
    output logic             o_overflow
);

    logic [Width-1:0] r_count;
    logic             r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= Width'(Max);
            r_err   <= 1'b0;
        end else begin
            unique case ({i_inc, i_dec})
                2'b10: begin
                    if (r_count == Width'(Max))
                        r_err <= 1'b1;
                    else
                        r_count <= r_count + Width'(1);
                end
                2'b01: begin
                    if (r_count != '0)
                        r_count <= r_count - Width'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_err;

endmodule

// File: rtl/noc_mcast_injector.sv
// Local-port multicast injector: turns a send request plus payload
// stream into head/payload flits, one packet in flight, credit gated.
module noc_mcast_injector
    import noc::*;
#(
    parameter int DataWidth  = FlitDataWidth,
    parameter int MaxLen     = 16,
    parameter int QueueDepth = PortQueueDepth,
    localparam int LenWidth  = $clog2(MaxLen + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  xy_t                  req_source,
    input  xy_t [NumDest-1:0]    req_dest,
    input  logic [NumDest-1:0]   req_val,
    input  message_t             req_msg,
    input  logic [LenWidth-1:0]  req_len,
    input  logic                 pl_valid,
    output logic                 pl_ready,
    input  logic [DataWidth-1:0] pl_data,
    output logic [DataWidth+1:0] data_out,
    output logic                 data_void_out,
    input  logic                 credit_in,
    output logic                 drop_pulse,
    output logic                 err_credit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_PAYLOAD
    } state_t;

    state_t               r_state;
    state_t               w_next;
    packet_info_t         r_info;
    logic [LenWidth-1:0]  r_len;
    logic [LenWidth-1:0]  r_rem;
    logic [DataWidth+1:0] r_flit;
    logic                 r_void;
    logic                 r_drop;

    logic [CreditsWidth-1:0] w_credits;
    logic                    w_has_credit;
    logic                    w_issue;
    logic                    w_accept;
    logic                    w_bad;
    logic [DataWidth+1:0]    w_flit;
    flit_t                   w_head;

    noc_credit_counter #(
        .Max   (QueueDepth),
        .Width (CreditsWidth)
    ) u_credits (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (credit_in),
        .i_dec      (w_issue),
        .o_count    (w_credits),
        .o_overflow (err_credit)
    );

    assign w_has_credit = (w_credits != '0);

    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_flit    = '0;
        w_accept  = 1'b0;
        w_bad     = 1'b0;
        req_ready = 1'b0;
        pl_ready  = 1'b0;
        w_head    = make_head_flit(r_info);
        w_head.pre.tail = (r_len == '0);
        unique case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                w_accept  = req_valid && !rst;
                w_bad     = (req_val == '0) ||
                            (req_len > LenWidth'(MaxLen));
                if (w_accept && !w_bad)
                    w_next = S_HEAD;
            end
            S_HEAD: begin
                if (w_has_credit) begin
                    w_issue = 1'b1;
                    w_flit  = {w_head.pre,
                               DataWidth'(w_head.body)};
                    w_next  = (r_len == '0) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                pl_ready = w_has_credit;
                if (pl_valid && w_has_credit) begin
                    w_issue = 1'b1;
                    w_flit  = {1'b0,
                               r_rem == LenWidth'(1),
                               pl_data};
                    if (r_rem == LenWidth'(1))
                        w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_info <= '0;
            r_len  <= '0;
            r_rem  <= '0;
            r_flit <= '0;
            r_void <= 1'b1;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept && w_bad;
            r_void <= !w_issue;
            if (w_issue)
                r_flit <= w_flit;
            // Fields only load in IDLE, so they hold for the whole packet.
            if (w_accept) begin
                r_info <= packet_info_t'{
                    source: req_source,
                    dest:   req_dest,
                    msg:    req_msg,
                    val:    req_val
                };
                r_len  <= req_len;
            end
            if (w_issue && r_state == S_HEAD)
                r_rem <= r_len;
            else if (w_issue && r_state == S_PAYLOAD)
                r_rem <= r_rem - LenWidth'(1);
        end
    end

    assign data_out      = r_flit;
    assign data_void_out = r_void;
    assign drop_pulse    = r_drop;

endmodule
